// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S ADC receive path.
//   I2S_DATA_W_DEF : default payload bits kept per channel
//   I2S_SYNC_DEF   : default synchronizer depth for the codec pins
//   ST_*           : receiver FSM state encoding (IDLE / LEFT / RIGHT)
package i2s_pkg;

    localparam int I2S_DATA_W_DEF = 16;
    localparam int I2S_SYNC_DEF   = 2;

    typedef logic [1:0] i2s_state_t;

    localparam i2s_state_t ST_IDLE  = 2'd0;
    localparam i2s_state_t ST_LEFT  = 2'd1;
    localparam i2s_state_t ST_RIGHT = 2'd2;

endpackage

// File: rtl/i2s_sync_edge.sv
// Multi-stage synchronizer with registered rising-edge detect.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig_i      : asynchronous strobe (codec bit clock)
//   aux_i      : asynchronous companion pins (lrc, dat)
//   rise_o     : one-clk pulse on each synced 0->1 of sig_i
//   aux_o      : aux_i taken through the same stages, aligned with rise_o
module i2s_sync_edge #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned AUX_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_i,
    input  logic [AUX_W-1:0] aux_i,
    output logic             rise_o,
    output logic [AUX_W-1:0] aux_o
);

    // Strobe and companions share one vector so every bit sees identical delay.
    logic [AUX_W:0] stage_q [STAGES];
    logic           prev_q;
    logic           rise_q;
    logic [AUX_W-1:0] aux_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            aux_q  <= '0;
        end else begin
            stage_q[0] <= {aux_i, sig_i};
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            prev_q <= stage_q[STAGES-1][0];
            rise_q <= stage_q[STAGES-1][0] & ~prev_q;
            aux_q  <= stage_q[STAGES-1][AUX_W:1];
        end
    end

    assign rise_o = rise_q;
    assign aux_o  = aux_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S receiver for the WM8731 ADC path (codec is bus master).
//   clk, rst_n         : system clock (>= 8x bclk), asynchronous active-low reset
//   en                 : receive enable, low forces IDLE
//   i2s_bclk/lrc/dat   : codec pins (asynchronous)
//   sample_l/sample_r  : received word pair, valid while sample_valid
//   sample_valid/ready : pair handshake, held until accepted
//   overrun            : 1-clk pulse, a completed pair was dropped
//   frame_err          : 1-clk pulse, a slot held fewer than DATA_W bits
module i2s_adc_rx
    import i2s_pkg::*;
#(
    parameter int DATA_W      = I2S_DATA_W_DEF,
    parameter int SYNC_STAGES = I2S_SYNC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              i2s_bclk,
    input  logic              i2s_lrc,
    input  logic              i2s_dat,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overrun,
    output logic              frame_err
);

    localparam int CW = $clog2(DATA_W + 1);

    logic rise_s;
    logic lrc_s;
    logic dat_s;

    i2s_sync_edge #(
        .STAGES (SYNC_STAGES),
        .AUX_W  (2)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (i2s_bclk),
        .aux_i  ({i2s_dat, i2s_lrc}),
        .rise_o (rise_s),
        .aux_o  ({dat_s, lrc_s})
    );

    i2s_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              lrc_prev_q, lrc_prev_d;
    logic [DATA_W-1:0] word_l_q, word_l_d;
    logic [DATA_W-1:0] word_r_q, word_r_d;
    logic              pair_done_q, pair_done_d;
    logic              ferr_q, ferr_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d;
    logic [DATA_W-1:0] hold_r_q, hold_r_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    logic [DATA_W-1:0] shift_in;
    logic [CW-1:0]     cnt_in;
    logic [DATA_W-1:0] justified;
    logic              boundary;
    logic              accept;

    // Receive FSM, shift register and bit counter.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        lrc_prev_d  = lrc_prev_q;
        word_l_d    = word_l_q;
        word_r_d    = word_r_q;
        pair_done_d = 1'b0;
        ferr_d      = 1'b0;

        // Word as it would stand with the current edge's bit included.
        shift_in = shift_q;
        cnt_in   = cnt_q;
        if (cnt_q < CW'(DATA_W)) begin
            shift_in = {shift_q[DATA_W-2:0], dat_s};
            cnt_in   = cnt_q + CW'(1);
        end
        // Bits fill from the LSB; shift up so short slots are left-justified.
        justified = shift_in << (CW'(DATA_W) - cnt_in);

        boundary = rise_s && (lrc_s != lrc_prev_q);
        if (rise_s) begin
            lrc_prev_d = lrc_s;
        end

        if (!en) begin
            state_d = ST_IDLE;
            shift_d = '0;
            cnt_d   = '0;
        end else if (rise_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (boundary && !lrc_s) begin
                        state_d = ST_LEFT;
                        shift_d = '0;
                        cnt_d   = '0;
                    end
                end
                ST_LEFT, ST_RIGHT: begin
                    if (boundary) begin
                        shift_d = '0;
                        cnt_d   = '0;
                        ferr_d  = (cnt_in < CW'(DATA_W));
                        if (state_q == ST_LEFT) begin
                            word_l_d = justified;
                            state_d  = ST_RIGHT;
                        end else begin
                            word_r_d    = justified;
                            pair_done_d = 1'b1;
                            state_d     = ST_LEFT;
                        end
                    end else begin
                        shift_d = shift_in;
                        cnt_d   = cnt_in;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output holding registers and valid/ready handshake.
    always_comb begin
        accept   = valid_q && sample_ready;
        valid_d  = valid_q;
        hold_l_d = hold_l_q;
        hold_r_d = hold_r_q;
        ovr_d    = 1'b0;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (pair_done_q) begin
            if (!valid_q || accept) begin
                hold_l_d = word_l_q;
                hold_r_d = word_r_q;
                valid_d  = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            lrc_prev_q  <= 1'b0;
            word_l_q    <= '0;
            word_r_q    <= '0;
            pair_done_q <= 1'b0;
            ferr_q      <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            lrc_prev_q  <= lrc_prev_d;
            word_l_q    <= word_l_d;
            word_r_q    <= word_r_d;
            pair_done_q <= pair_done_d;
            ferr_q      <= ferr_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign sample_l     = hold_l_q;
    assign sample_r     = hold_r_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
    assign frame_err    = ferr_q;

endmodule
